// File: rtl/y86_execute_stage_if.sv
// Decode-to-execute and execute-to-memory bus for the Y86 execute stage.
// The stage uses the slave modport. The producer/consumer side uses master.
interface y86_execute_stage_if #(parameter int WIDTH = 64);
  logic             in_valid, in_ready;
  logic [3:0]       icode, ifun;
  logic [WIDTH-1:0] valA, valB, valC;
  logic [3:0]       dstE_in, dstM_in;
  logic             flush, cc_hold;
  logic             out_valid, out_ready;
  logic [3:0]       out_icode;
  logic [WIDTH-1:0] out_valE, out_valA;
  logic             out_cnd;
  logic [3:0]       out_dstE, out_dstM;
  logic [2:0]       cc;

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, dstE_in, dstM_in,
           flush, cc_hold, out_ready,
    output in_ready, out_valid, out_icode, out_valE, out_valA, out_cnd,
           out_dstE, out_dstM, cc
  );

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, dstE_in, dstM_in,
           flush, cc_hold, out_ready,
    input  in_ready, out_valid, out_icode, out_valE, out_valA, out_cnd,
           out_dstE, out_dstM, cc
  );
endinterface

// File: rtl/y86_execute_stage.sv
// Y86 execute stage: ALU, condition codes, branch/cmov condition, E->M register.
// Single-entry output register with valid/ready, flush squash, synchronous reset.
module y86_execute_stage #(
  parameter int         WIDTH      = 64,
  parameter int         STACK_STEP = 8,
  parameter logic [3:0] RNONE      = 4'hF
) (
  input logic               clk,
  input logic               rst,
  y86_execute_stage_if.slave bus
);
  logic [WIDTH-1:0] alu_a, alu_b, alu_e;
  logic [3:0]       alu_fn;
  logic             alu_of, cond, accept, cc_we;
  logic [2:0]       cc_q, cc_new;

  logic             vld_q;
  logic [3:0]       icode_q, dste_q, dstm_q;
  logic [WIDTH-1:0] vale_q, vala_q;
  logic             cnd_q;

  assign bus.in_ready = !vld_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_a = '0;
    unique case (bus.icode)
      4'h2, 4'h6:       alu_a = bus.valA;
      4'h3, 4'h4, 4'h5: alu_a = bus.valC;
      4'h8, 4'hA:       alu_a = '0 - WIDTH'(STACK_STEP);
      4'h9, 4'hB:       alu_a = WIDTH'(STACK_STEP);
      default:          alu_a = '0;
    endcase
  end

  assign alu_b  = (bus.icode >= 4'h2 && bus.icode <= 4'hB && bus.icode != 4'h3) ? bus.valB : '0;
  assign alu_fn = (bus.icode == 4'h6) ? bus.ifun : 4'h0;

  always_comb begin
    alu_e  = '0;
    alu_of = 1'b0;
    case (alu_fn)
      4'h0: begin
        alu_e  = alu_a + alu_b;
        alu_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_e[WIDTH-1] != alu_a[WIDTH-1]);
      end
      4'h1: begin
        alu_e  = alu_b - alu_a;
        alu_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_e[WIDTH-1] != alu_b[WIDTH-1]);
      end
      4'h2:    alu_e = alu_a & alu_b;
      4'h3:    alu_e = alu_a ^ alu_b;
      default: alu_e = '0;
    endcase
  end

  assign cc_new = {alu_e == '0, alu_e[WIDTH-1], alu_of};
  assign cc_we  = accept && bus.icode == 4'h6 && bus.ifun <= 4'h3 && !bus.flush && !bus.cc_hold;

  // Condition reads the registered CC, i.e. the value before this cycle's write.
  always_comb begin
    cond = 1'b0;
    case (bus.ifun)
      4'h0: cond = 1'b1;
      4'h1: cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'h2: cond = cc_q[1] ^ cc_q[0];
      4'h3: cond = cc_q[2];
      4'h4: cond = !cc_q[2];
      4'h5: cond = !(cc_q[1] ^ cc_q[0]);
      4'h6: cond = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q    <= 3'b100;
      vld_q   <= 1'b0;
      icode_q <= '0;
      vale_q  <= '0;
      vala_q  <= '0;
      cnd_q   <= 1'b0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
    end else begin
      if (cc_we) cc_q <= cc_new;
      if (bus.flush) begin
        vld_q <= 1'b0;
      end else if (accept) begin
        vld_q   <= 1'b1;
        icode_q <= bus.icode;
        vale_q  <= alu_e;
        vala_q  <= bus.valA;
        cnd_q   <= (bus.icode == 4'h2 || bus.icode == 4'h7) ? cond : 1'b1;
        dste_q  <= (bus.icode == 4'h2 && !cond) ? RNONE : bus.dstE_in;
        dstm_q  <= bus.dstM_in;
      end else if (bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_icode = icode_q;
  assign bus.out_valE  = vale_q;
  assign bus.out_valA  = vala_q;
  assign bus.out_cnd   = cnd_q;
  assign bus.out_dstE  = dste_q;
  assign bus.out_dstM  = dstm_q;
  assign bus.cc        = cc_q;
endmodule

// File: doc/y86_execute_stage.md
# y86_execute_stage

Pipelined, parametrised execute stage for the Y86 processor: computes valE through a 4-function ALU, holds the condition-code register, evaluates branch and cmov conditions, and registers results into the E→M pipeline register. A valid/ready handshake and a flush input let it stall and squash. It sits between the decode pipeline register and the memory stage.

## Interface
Parameters:
- WIDTH, 64, datapath width (≥8)
- STACK_STEP, 8, stack pointer adjustment for call/ret/pushq/popq
- RNONE, 4'hF, register ID meaning "no destination"

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decode side presents an instruction
- in_ready  output  1  stage accepts this cycle
- icode  input  4  instruction code
- ifun  input  4  function code
- valA, valB, valC  input  WIDTH  operands from decode
- dstE_in, dstM_in  input  4  destination register IDs
- flush  input  1  squash: discard accepted instruction and register contents
- cc_hold  input  1  downstream exception; suppress CC update
- out_valid  output  1  E→M register holds an instruction
- out_ready  input  1  memory stage consumes
- out_icode  output  4
- out_valE, out_valA  output  WIDTH
- out_cnd  output  1  condition result
- out_dstE, out_dstM  output  4
- cc  output  3  {ZF,SF,OF}, current CC register

## Operation
- ALU_A: valA for icode 2,6; valC for 3,4,5; −STACK_STEP for 8,A; +STACK_STEP for 9,B; 0 otherwise.
- ALU_B: valB for icode 2–B except 3 (0); 0 for 0,1, and invalid codes (>B).
- ALU function: ifun for icode 6, add otherwise. 0 add A+B, 1 sub B−A, 2 and, 3 xor; ifun>3 with icode 6 yields valE=0 and no CC update.
- All arithmetic is modulo 2^WIDTH; carry is discarded.
- Flags from result E: ZF = (E==0); SF = E[WIDTH-1]. OF: add = (A sign == B sign) && (E sign != A sign); sub = (A sign != B sign) && (E sign != B sign); and/xor = 0.
- CC is written only when an instruction is accepted (in_valid && in_ready), icode==6, ifun≤3, !flush, and !cc_hold.
- Condition evaluation uses the CC value before any same-cycle update. Cond on ifun: 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; >6 → 0. out_cnd = cond for icode 2 and 7; 1 otherwise.
- cmov (icode 2) with cond=0 gives out_dstE = RNONE. Otherwise dstE_in passes through; dstM_in always passes through.

## Timing
- Latency 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- in_ready = !out_valid || out_ready (combinational; no skid buffer).
- Output register loads on accept. It holds unchanged while out_valid && !out_ready. out_valid clears when consumed without a new accept.
- flush: at the next edge out_valid=0, and any same-cycle accept is discarded (no CC write). Flush has priority over accept and stall.
- Reset (sampled at edge, overrides everything): out_valid=0, all out_* data=0, out_dstE=out_dstM=RNONE, out_cnd=0, cc=3'b100. Reset mid-stall drops the held instruction.
- Back-to-back OPq: instruction k+1's cond/CC view sees instruction k's CC write (register updated at the edge k is accepted).

## Test plan
- Reset then OPq add: valA=5, valB=7 → out_valE=12, next-cycle cc=3'b000, out_valid=1 one cycle after accept.
- OPq sub: valA=1, valB=0x8000…0000 → valE=0x7FFF…FFFF, cc=3'b001 (OF). Next, jXX ifun=5 (ge) → out_cnd=0.
- cmovXX ifun=3 with ZF=0, dstE_in=3 → out_dstE=RNONE, out_valE=valA. With ZF=1 → out_dstE=3.
- pushq valB=0x100 → valE=0xF8. popq valB=0x100 → valE=0x108. cc unchanged for both.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen; then out_ready=1 → next instruction appears after one edge, none lost or duplicated.
- OPq xor valA=valB=9 accepted with flush=1 (and separately with cc_hold=1) → no CC change, and out_valid=0 in the flush case.
